mult_seq: RTL and testbench

- Parametrised multi-cycle shift-add multiplier sequencer for the pico MIPS datapath.
- Sits between the instruction decoder and the register file read/write ports.
- While idle, decoder read addresses pass straight through to the register file.
- While a multiply runs, it owns the read ports, stalls the core and then writes the fixed-point (upper-half) product to the accumulator register.

---
 rtl/mult_pkg.sv | 7 +
 rtl/mult_seq_if.sv | 22 ++
 rtl/mult_seq_shift_add_core.sv | 52 +++++
 rtl/mult_seq.sv | 55 +++++
 tb/tb_mult_seq.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared sequencer state type and default geometry for the pico MIPS shift-add multiplier.
package mult_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, RUN, WRITE} mult_state_t;
   localparam int MULT_DATA_W  = 8;
   localparam int MULT_ADDR_W  = 3;
   localparam int MULT_ACC_REG = 2;
endpackage

// File: rtl/mult_seq_if.sv
// mult_seq_if: decoder/register-file side of the multiplier; master drives requests and read data, slave is the sequencer.
interface mult_seq_if import mult_pkg::*; #(
   parameter int DATA_W = MULT_DATA_W,
   parameter int ADDR_W = MULT_ADDR_W
);
   logic              start;
   logic [ADDR_W-1:0] prog_address;
   logic [ADDR_W-1:0] prog_address2;
   logic [DATA_W-1:0] rd_data1;
   logic [DATA_W-1:0] rd_data2;
   logic [ADDR_W-1:0] address;
   logic [ADDR_W-1:0] address2;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_address;
   logic [DATA_W-1:0] wr_data;
   logic              busy;
   logic              done;
   modport master (output start, prog_address, prog_address2, rd_data1, rd_data2,
                   input  address, address2, wr_en, wr_address, wr_data, busy, done);
   modport slave  (input  start, prog_address, prog_address2, rd_data1, rd_data2,
                   output address, address2, wr_en, wr_address, wr_data, busy, done);
endinterface

// File: rtl/mult_seq_shift_add_core.sv
// shift_add_core: registered shift-add datapath (acc, mcand, mplier, cnt).
// With MULT_SIGNED_EN defined it multiplies magnitudes and re-applies the sign to the full product.
module shift_add_core import mult_pkg::*; #(
   parameter int DATA_W = MULT_DATA_W
) (
   input  logic              clk,
   input  logic              n_reset,
   input  logic              load_i,
   input  logic              step_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic              last_o,
   output logic [DATA_W-1:0] prod_hi_o
);
   localparam int CNT_W = $clog2(DATA_W);
   logic [2*DATA_W-1:0] acc_q, acc_d, prod;
   logic [DATA_W-1:0]   mcand_q, mcand_d, mplier_q, mplier_d, a_mag, b_mag;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
`ifdef MULT_SIGNED_EN
   logic neg_q, neg_d;
   assign a_mag = a_i[DATA_W-1] ? -a_i : a_i;
   assign b_mag = b_i[DATA_W-1] ? -b_i : b_i;
   assign neg_d = load_i ? a_i[DATA_W-1] ^ b_i[DATA_W-1] : neg_q;
   assign prod  = neg_q ? -acc_d : acc_d;
   always_ff @(posedge clk or negedge n_reset)
      if (!n_reset) neg_q <= 1'b0;
      else neg_q <= neg_d;
`else
   assign a_mag = a_i;
   assign b_mag = b_i;
   assign prod  = acc_d;
`endif
   assign last_o   = cnt_q == CNT_W'(DATA_W-1);
   assign acc_d    = load_i ? '0 : (step_i && mplier_q[0]) ? acc_q + ({{DATA_W{1'b0}}, mcand_q} << cnt_q) : acc_q;
   assign mcand_d  = load_i ? a_mag : mcand_q;
   assign mplier_d = load_i ? b_mag : step_i ? mplier_q >> 1 : mplier_q;
   assign cnt_d    = load_i ? '0 : (step_i && !last_o) ? cnt_q + CNT_W'(1) : cnt_q;
   // Product of this cycle's step, so the final sum is available at the edge that enters WRITE
   assign prod_hi_o = DATA_W'(prod >> DATA_W);
   always_ff @(posedge clk or negedge n_reset)
      if (!n_reset) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
      end
endmodule

// File: rtl/mult_seq.sv
// mult_seq: multi-cycle multiplier sequencer; owns the register-file read ports while busy and writes the
// upper-half product to ACC_REG. Define MULT_SIGNED_EN for two's-complement operands.
module mult_seq import mult_pkg::*; #(
   parameter int                DATA_W  = MULT_DATA_W,
   parameter int                ADDR_W  = MULT_ADDR_W,
   parameter logic [ADDR_W-1:0] ACC_REG = ADDR_W'(MULT_ACC_REG)
) (
   input logic       clk,
   input logic       n_reset,
   mult_seq_if.slave bus
);
   mult_state_t       state_q, state_d;
   logic [ADDR_W-1:0] hold_q, hold_d;
   logic              wr_en_q, wr_en_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d, prod_hi;
   logic              last, fin, own;
   shift_add_core #(.DATA_W(DATA_W)) u_core (
      .clk       (clk),
      .n_reset   (n_reset),
      .load_i    (state_q == LOAD),
      .step_i    (state_q == RUN),
      .a_i       (bus.rd_data1),
      .b_i       (bus.rd_data2),
      .last_o    (last),
      .prod_hi_o (prod_hi)
   );
   assign fin       = state_q == RUN && last;
   assign state_d   = state_q == IDLE ? (bus.start ? LOAD : IDLE) :
                      state_q == LOAD ? RUN :
                      state_q == RUN  ? (last ? WRITE : RUN) : IDLE;
   assign hold_d    = (state_q == IDLE && bus.start) ? bus.prog_address : hold_q;
   assign wr_en_d   = fin;
   assign wr_data_d = fin ? prod_hi : wr_data_q;
   always_ff @(posedge clk or negedge n_reset)
      if (!n_reset) begin
         state_q   <= IDLE;
         hold_q    <= '0;
         wr_en_q   <= 1'b0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         wr_en_q   <= wr_en_d;
         wr_data_q <= wr_data_d;
      end
   // Operands are read through the decoder addresses until LOAD latches them
   assign own            = state_q == RUN || state_q == WRITE;
   assign bus.address    = own ? ACC_REG : bus.prog_address;
   assign bus.address2   = own ? hold_q : bus.prog_address2;
   assign bus.wr_en      = wr_en_q;
   assign bus.done       = wr_en_q;
   assign bus.wr_address = ACC_REG;
   assign bus.wr_data    = wr_data_q;
   assign bus.busy       = state_q != IDLE;
endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq: random and directed checks of mult_seq against a cycle-schedule model with arithmetic products.
module tb_mult_seq;
   localparam int W = 8;
   localparam int AW = 3;
   localparam logic [AW-1:0] ACC = 3'd2;
`ifdef MULT_SIGNED_EN
   localparam logic [W-1:0] E_C0_80 = 8'h20, E_FF_FF = 8'h00, E_C0_40 = 8'hF0, E_80_80 = 8'h40;
`else
   localparam logic [W-1:0] E_C0_80 = 8'h60, E_FF_FF = 8'hFE, E_C0_40 = 8'h30, E_80_80 = 8'h40;
`endif
   logic clk = 1'b0;
   logic n_reset = 1'b0;
   always #5 clk = ~clk;

   mult_seq_if #(.DATA_W(W), .ADDR_W(AW)) bus ();
   mult_seq #(.DATA_W(W), .ADDR_W(AW), .ACC_REG(ACC)) dut (.clk(clk), .n_reset(n_reset), .bus(bus));
   logic [W-1:0] rf [8];
   assign bus.rd_data1 = rf[bus.address];
   assign bus.rd_data2 = rf[bus.address2];

   mult_seq_if #(.DATA_W(16), .ADDR_W(4)) bus16 ();
   mult_seq #(.DATA_W(16), .ADDR_W(4), .ACC_REG(4'd7)) dut16 (.clk(clk), .n_reset(n_reset), .bus(bus16));
   logic [15:0] rf16 [16];
   assign bus16.rd_data1 = rf16[bus16.address];
   assign bus16.rd_data2 = rf16[bus16.address2];

   int vectors = 0;
   int miscompares = 0;

   function automatic void chk(string name, longint act, longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic logic [W-1:0] ref_hi(logic [W-1:0] a, logic [W-1:0] b);
      longint p;
`ifdef MULT_SIGNED_EN
      p = longint'($signed(a)) * longint'($signed(b));
`else
      p = longint'(a) * longint'(b);
`endif
      return W'(p >> W);
   endfunction

   // Model: ph = -1 idle, 0 load, 1..W run, W+1 write
   int ph = -1;
   logic [AW-1:0] hold_m = '0;
   logic [W-1:0] exp_m = '0;
   initial forever begin
      @(posedge clk or negedge n_reset);
      if (!n_reset) ph = -1;
      else if (ph == -1) begin
         if (bus.start) begin ph = 0; hold_m = bus.prog_address; end
      end else if (ph == 0) begin
         exp_m = ref_hi(rf[bus.prog_address], rf[bus.prog_address2]);
         ph = 1;
      end else if (ph == W + 1) ph = -1;
      else ph++;
   end

   initial forever begin
      @(negedge clk);
      if (n_reset) begin
         chk("busy", bus.busy, ph >= 0);
         chk("wr_en", bus.wr_en, ph == W + 1);
         chk("done", bus.done, ph == W + 1);
         chk("wr_address", bus.wr_address, ACC);
         chk("address", bus.address, ph >= 1 ? ACC : bus.prog_address);
         chk("address2", bus.address2, ph >= 1 ? hold_m : bus.prog_address2);
         if (ph == W + 1) chk("wr_data", bus.wr_data, exp_m);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic run_op(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [W-1:0] exp, input string nm);
      int n;
      bus.prog_address = a;
      bus.prog_address2 = b;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      n = 0;
      while (!bus.wr_en && n < 40) begin tick(); n++; end
      chk({nm, "_latency"}, n, W + 1);
      chk({nm, "_data"}, bus.wr_data, exp);
      chk({nm, "_wr_address"}, bus.wr_address, ACC);
      tick();
      chk({nm, "_done_pulse"}, bus.done, 0);
      chk({nm, "_idle"}, bus.busy, 0);
   endtask

   initial begin
      int n, pulses;
      logic idle_seen;
      bus.start = 1'b0; bus.prog_address = '0; bus.prog_address2 = '0;
      bus16.start = 1'b0; bus16.prog_address = '0; bus16.prog_address2 = '0;
      foreach (rf[i]) rf[i] = '0;
      foreach (rf16[i]) rf16[i] = '0;
      #1;
      chk("rst_busy", bus.busy, 0);
      chk("rst_wr_en", bus.wr_en, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_wr_data", bus.wr_data, 0);
      repeat (2) tick();
      n_reset = 1'b1;
      tick();
      bus.prog_address = 3'd5; bus.prog_address2 = 3'd6;
      #1;
      chk("pt_address", bus.address, 5);
      chk("pt_address2", bus.address2, 6);
      rf[3] = 8'hC0; rf[4] = 8'h80; rf[5] = 8'hC0; rf[6] = 8'h40; rf[7] = 8'h80;
      tick();
      run_op(3'd3, 3'd4, E_C0_80, "op_c0x80");
      run_op(3'd5, 3'd6, E_C0_40, "op_c0x40");
      run_op(3'd7, 3'd7, E_80_80, "op_80sq");
      // start re-pulsed during RUN
      bus.prog_address = 3'd3; bus.prog_address2 = 3'd6; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      pulses = 0;
      for (int i = 0; i < W + 6; i++) begin
         if (i == 4) bus.start = 1'b1;
         if (i == 5) bus.start = 1'b0;
         tick();
         pulses += int'(bus.wr_en);
      end
      chk("repulse_writes", pulses, 1);
      // start held high: one write per operation with an idle cycle in between
      bus.start = 1'b1;
      pulses = 0;
      idle_seen = 1'b1;
      for (int i = 0; i < 3 * (W + 3); i++) begin
         tick();
         if (bus.wr_en) begin
            chk("held_idle_gap", idle_seen, 1);
            pulses++;
            idle_seen = 1'b0;
         end
         if (!bus.busy) idle_seen = 1'b1;
      end
      bus.start = 1'b0;
      chk("held_writes", pulses, 3);
      repeat (W + 4) tick();
      // reset in the middle of RUN
      rf[1] = 8'hFF; rf[2] = 8'hFF;
      bus.prog_address = 3'd1; bus.prog_address2 = 3'd2; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (5) tick();
      n_reset = 1'b0;
      #1;
      chk("arst_busy", bus.busy, 0);
      chk("arst_wr_en", bus.wr_en, 0);
      chk("arst_done", bus.done, 0);
      chk("arst_wr_data", bus.wr_data, 0);
      tick();
      n_reset = 1'b1;
      pulses = 0;
      for (int i = 0; i < W + 4; i++) begin tick(); pulses += int'(bus.wr_en); end
      chk("arst_no_write", pulses, 0);
      run_op(3'd1, 3'd2, E_FF_FF, "op_ffxff");
      // random traffic against the model
      for (int i = 0; i < 400; i++) begin
         bus.start = $urandom_range(0, 3) == 0;
         bus.prog_address = AW'($urandom_range(0, 7));
         bus.prog_address2 = AW'($urandom_range(0, 7));
         rf[$urandom_range(0, 7)] = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
         tick();
      end
      bus.start = 1'b0;
      repeat (W + 4) tick();
      // 16-bit instance
      rf16[9] = 16'h8000; rf16[10] = 16'h8000;
      bus16.prog_address = 4'd9; bus16.prog_address2 = 4'd10; bus16.start = 1'b1;
      tick();
      bus16.start = 1'b0;
      n = 0;
      while (!bus16.wr_en && n < 60) begin
         tick();
         n++;
         if (n == 3) begin
            chk("w16_run_address", bus16.address, 7);
            chk("w16_run_address2", bus16.address2, 9);
         end
      end
      chk("w16_latency", n, 17);
      chk("w16_data", bus16.wr_data, 16'h4000);
      chk("w16_wr_address", bus16.wr_address, 7);
      tick();
      chk("w16_idle", bus16.busy, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
